// File: rtl/maverickOne_pkg.sv
// Shared core types: decoded instruction record, register-file size and
// the system-wide issue queue depth.
package maverickOne_pkg;

   localparam int NUM_REGS          = 32;
   localparam int REG_AW            = $clog2(NUM_REGS);
   localparam int TAG_W             = 8;
   localparam int ISSUE_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [REG_AW-1:0]   rd;
      logic [NUM_REGS-1:0] reg_req;
      logic                blocking;
   } decoded_instr_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
      reg_onehot = NUM_REGS'(1'b1) << r;
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Enqueue and launch handshakes of the issue queue; the queue takes the
// slave view, producer/consumer (or bench) the master view.
interface issue_queue_if;
   import maverickOne_pkg::*;

   decoded_instr_t instr_in_i;
   logic           instr_in_valid_i;
   logic           instr_in_ready_o;
   decoded_instr_t instr_out_o;
   logic           instr_out_valid_o;
   logic           instr_out_ready_i;

   modport master (
      output instr_in_i, instr_in_valid_i, instr_out_ready_i,
      input  instr_in_ready_o, instr_out_o, instr_out_valid_o
   );

   modport slave (
      input  instr_in_i, instr_in_valid_i, instr_out_ready_i,
      output instr_in_ready_o, instr_out_o, instr_out_valid_o
   );

endinterface

// File: rtl/issue_hazard_ckr.sv
// Per-slot launch eligibility; also extends the hazard mask and blocking
// flag seen by the next younger slot.
module issue_hazard_ckr
   import maverickOne_pkg::*;
#(
   parameter int NR       = NUM_REGS,
   parameter int SLOT     = 0,
   parameter int IN_ORDER = 0
) (
   input  logic           slot_valid,
   input  decoded_instr_t instr,
   input  logic [NR-1:0]  acc_in,
   input  logic           older_blocking_in,
   output logic           eligible,
   output logic [NR-1:0]  acc_out,
   output logic           blocking_out
);

   localparam logic IS_HEAD   = (SLOT == 0) ? 1'b1 : 1'b0;
   localparam logic MAY_SKIP  = ((IN_ORDER == 0) || (SLOT == 0)) ? 1'b1 : 1'b0;
   // x0 is never a real dependency
   localparam logic [NR-1:0] X0_MASK = ~NR'(1'b1);

   logic [NR-1:0] own_s;
   logic          hazard_s;

   // Eligibility and mask chaining for this slot
   always_comb begin
      own_s        = NR'(reg_onehot(instr.rd) | instr.reg_req);
      hazard_s     = |(own_s & acc_in);
      eligible     = slot_valid & ~hazard_s & ~older_blocking_in
                     & (IS_HEAD | ~instr.blocking) & MAY_SKIP;
      acc_out      = (acc_in | (slot_valid ? own_s : {NR{1'b0}})) & X0_MASK;
      blocking_out = older_blocking_in | (slot_valid & instr.blocking);
   end

endmodule

// File: rtl/issue_queue.sv
// Age-ordered issue queue: slot 0 is oldest, launch picks the oldest
// hazard-free slot and collapses younger entries down in the same edge.
module issue_queue
   import maverickOne_pkg::*;
#(
   parameter int DEPTH    = ISSUE_QUEUE_DEPTH,
   parameter int IN_ORDER = 0,
   parameter int NR       = NUM_REGS
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic                       clear_i,
   input  logic [NR-1:0]              locks_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   issue_queue_if.slave               iq
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   decoded_instr_t slots_r [DEPTH];
   logic [CW-1:0]  count_r;

   logic [DEPTH-1:0] valid_s;
   logic [DEPTH-1:0] elig_s;
   logic [NR-1:0]    acc_s [DEPTH];
   logic [DEPTH-1:0] blk_s;
   logic [NR-1:0]    acc_tail_unused;
   logic             blk_tail_unused;

   logic [IW-1:0] sel_s;
   logic          any_s;
   logic          enq_s;
   logic          launch_s;
   logic [CW-1:0] wr_idx_s;

   assign acc_s[0] = locks_i & ~NR'(1'b1);
   assign blk_s[0] = 1'b0;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_slot
         assign valid_s[g] = (CW'(g) < count_r);
         if (g < DEPTH-1) begin : g_mid
            issue_hazard_ckr #(.NR(NR), .SLOT(g), .IN_ORDER(IN_ORDER)) u_ckr (
               .slot_valid        (valid_s[g]),
               .instr             (slots_r[g]),
               .acc_in            (acc_s[g]),
               .older_blocking_in (blk_s[g]),
               .eligible          (elig_s[g]),
               .acc_out           (acc_s[g+1]),
               .blocking_out      (blk_s[g+1])
            );
         end else begin : g_tail
            issue_hazard_ckr #(.NR(NR), .SLOT(g), .IN_ORDER(IN_ORDER)) u_ckr (
               .slot_valid        (valid_s[g]),
               .instr             (slots_r[g]),
               .acc_in            (acc_s[g]),
               .older_blocking_in (blk_s[g]),
               .eligible          (elig_s[g]),
               .acc_out           (acc_tail_unused),
               .blocking_out      (blk_tail_unused)
            );
         end
      end
   endgenerate

   // Lowest eligible slot wins; output path is purely combinational
   always_comb begin
      sel_s = {IW{1'b0}};
      for (int k = DEPTH-1; k >= 0; k--) begin
         sel_s = elig_s[k] ? IW'(k) : sel_s;
      end
      any_s                = |elig_s;
      iq.instr_out_o       = slots_r[sel_s];
      iq.instr_out_valid_o = any_s & ~clear_i;
      iq.instr_in_ready_o  = (count_r < CW'(DEPTH)) & ~clear_i;
      enq_s                = iq.instr_in_valid_i & iq.instr_in_ready_o;
      launch_s             = iq.instr_out_valid_o & iq.instr_out_ready_i;
      // A same-cycle launch frees one slot below the current tail
      wr_idx_s             = launch_s ? (count_r - CW'(1'b1)) : count_r;
   end

   // Occupancy: flush wins over enqueue and launch
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         count_r <= {CW{1'b0}};
      end else if (clear_i) begin
         count_r <= {CW{1'b0}};
      end else if (enq_s && !launch_s) begin
         count_r <= count_r + CW'(1'b1);
      end else if (launch_s && !enq_s) begin
         count_r <= count_r - CW'(1'b1);
      end else begin
         count_r <= count_r;
      end
   end

   // Payload storage: collapse above the launched slot, then write the tail
   always_ff @(posedge clk_i) begin
      if (!clear_i) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (launch_s && (IW'(k) >= sel_s) && (k < DEPTH-1)) begin
               slots_r[k] <= slots_r[(k < DEPTH-1) ? k+1 : k];
            end
            if (enq_s && (CW'(k) == wr_idx_s)) begin
               slots_r[k] <= iq.instr_in_i;
            end
         end
      end
   end

   assign count_o = count_r;

endmodule

// File: tb/tb_issue_queue.sv
// Directed table-driven bench for issue_queue: out-of-order instance checked
// row by row, plus reset and in-order sequences.
module tb_issue_queue;
   import maverickOne_pkg::*;

   typedef struct {
      logic        ev;
      logic [7:0]  tg;
      logic [4:0]  rd;
      logic [31:0] rq;
      logic        bk;
      logic [31:0] lk;
      logic        ordy;
      logic        clr;
      logic        irdy;
      logic        ovld;
      logic [7:0]  otag;
      logic [2:0]  cnt;
   } vec_t;

   logic           clk = 1'b0;
   logic           arst;
   logic           clear;
   logic [31:0]    locks;
   decoded_instr_t in_instr;
   logic           in_valid;
   logic           out_ready;
   logic [2:0]     cnt0;
   logic [2:0]     cnt1;
   int             checks = 0;
   int             errors = 0;
   vec_t           tbl [39];

   always #5 clk = ~clk;

   issue_queue_if iq0 ();
   issue_queue_if iq1 ();

   assign iq0.instr_in_i        = in_instr;
   assign iq0.instr_in_valid_i  = in_valid;
   assign iq0.instr_out_ready_i = out_ready;
   assign iq1.instr_in_i        = in_instr;
   assign iq1.instr_in_valid_i  = in_valid;
   assign iq1.instr_out_ready_i = out_ready;

   issue_queue #(.DEPTH(4), .IN_ORDER(0), .NR(NUM_REGS)) dut0 (
      .clk_i(clk), .arst_i(arst), .clear_i(clear), .locks_i(locks),
      .count_o(cnt0), .iq(iq0)
   );

   issue_queue #(.DEPTH(4), .IN_ORDER(1), .NR(NUM_REGS)) dut1 (
      .clk_i(clk), .arst_i(arst), .clear_i(clear), .locks_i(locks),
      .count_o(cnt1), .iq(iq1)
   );

   function automatic vec_t mkv(input logic ev, input logic [7:0] tg, input logic [4:0] rd,
                                input logic [31:0] rq, input logic bk, input logic [31:0] lk,
                                input logic ordy, input logic clr, input logic irdy,
                                input logic ovld, input logic [7:0] otag, input logic [2:0] cnt);
      vec_t v;
      v.ev = ev; v.tg = tg; v.rd = rd; v.rq = rq; v.bk = bk; v.lk = lk;
      v.ordy = ordy; v.clr = clr; v.irdy = irdy; v.ovld = ovld; v.otag = otag; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ev, input logic [7:0] tg, input logic [4:0] rd,
                        input logic [31:0] rq, input logic bk, input logic [31:0] lk,
                        input logic ordy, input logic clr);
      in_valid          = ev;
      in_instr.tag      = tg;
      in_instr.rd       = rd;
      in_instr.reg_req  = rq;
      in_instr.blocking = bk;
      locks             = lk;
      out_ready         = ordy;
      clear             = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk0(input string n, input logic irdy, input logic ovld,
                       input logic [7:0] otag, input logic [2:0] cnt);
      chk({n, " in_ready"},  32'(iq0.instr_in_ready_o), 32'(irdy));
      chk({n, " out_valid"}, 32'(iq0.instr_out_valid_o), 32'(ovld));
      chk({n, " count"},     32'(cnt0), 32'(cnt));
      if (ovld) chk({n, " out_tag"}, 32'(iq0.instr_out_o.tag), 32'(otag));
   endtask

   task automatic chk1(input string n, input logic irdy, input logic ovld,
                       input logic [7:0] otag, input logic [2:0] cnt);
      chk({n, " in_ready"},  32'(iq1.instr_in_ready_o), 32'(irdy));
      chk({n, " out_valid"}, 32'(iq1.instr_out_valid_o), 32'(ovld));
      chk({n, " count"},     32'(cnt1), 32'(cnt));
      if (ovld) chk({n, " out_tag"}, 32'(iq1.instr_out_o.tag), 32'(otag));
   endtask

   initial begin
      //              ev tg     rd     rq          bk    lk          ordy  clr   irdy  ovld  otag   cnt
      // RAW: B waits on A's destination, independent C overtakes B
      tbl[0]  = mkv(1'b1, 8'd1,  5'd5,  32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[1]  = mkv(1'b1, 8'd2,  5'd0,  32'h20,   1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 8'd1,  3'd1);
      tbl[2]  = mkv(1'b1, 8'd3,  5'd7,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd1,  3'd2);
      tbl[3]  = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h20,   1'b0, 1'b0, 1'b1, 1'b1, 8'd3,  3'd2);
      tbl[4]  = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h20,   1'b1, 1'b0, 1'b1, 1'b1, 8'd3,  3'd2);
      tbl[5]  = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h20,   1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd1);
      tbl[6]  = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd2,  3'd1);
      tbl[7]  = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      // WAR: younger B writes r9 that stalled A still reads
      tbl[8]  = mkv(1'b1, 8'd4,  5'd1,  32'h208,  1'b0, 32'h8,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[9]  = mkv(1'b1, 8'd5,  5'd9,  32'h0,    1'b0, 32'h8,    1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd1);
      tbl[10] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h8,    1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd2);
      tbl[11] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd4,  3'd2);
      tbl[12] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd5,  3'd1);
      // Blocking Y behind stalled X holds back itself and Z
      tbl[13] = mkv(1'b1, 8'd6,  5'd2,  32'h10,   1'b0, 32'h10,   1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[14] = mkv(1'b1, 8'd7,  5'd3,  32'h0,    1'b1, 32'h10,   1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd1);
      tbl[15] = mkv(1'b1, 8'd8,  5'd10, 32'h0,    1'b0, 32'h10,   1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd2);
      tbl[16] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h10,   1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd3);
      tbl[17] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd6,  3'd3);
      tbl[18] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd7,  3'd2);
      tbl[19] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd8,  3'd1);
      // Full queue, launch while full, enqueue+launch at count 2
      tbl[20] = mkv(1'b1, 8'd9,  5'd11, 32'h8000, 1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[21] = mkv(1'b1, 8'd10, 5'd12, 32'h0,    1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd1);
      tbl[22] = mkv(1'b1, 8'd11, 5'd13, 32'h0,    1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 3'd2);
      tbl[23] = mkv(1'b1, 8'd12, 5'd14, 32'h0,    1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 3'd3);
      tbl[24] = mkv(1'b1, 8'd13, 5'd15, 32'h0,    1'b0, 32'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 3'd4);
      tbl[25] = mkv(1'b1, 8'd13, 5'd15, 32'h0,    1'b0, 32'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd10, 3'd4);
      tbl[26] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 8'd11, 3'd3);
      tbl[27] = mkv(1'b1, 8'd14, 5'd16, 32'h0,    1'b0, 32'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 8'd12, 3'd2);
      tbl[28] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14, 3'd2);
      tbl[29] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd9,  3'd2);
      tbl[30] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd14, 3'd1);
      // No bypass: enqueue into empty queue is not visible the same cycle
      tbl[31] = mkv(1'b1, 8'd15, 5'd17, 32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[32] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b1, 8'd15, 3'd1);
      tbl[33] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      // Flush with three entries, concurrent enqueue and launch suppressed
      tbl[34] = mkv(1'b1, 8'd16, 5'd18, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);
      tbl[35] = mkv(1'b1, 8'd17, 5'd19, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 8'd16, 3'd1);
      tbl[36] = mkv(1'b1, 8'd18, 5'd20, 32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 8'd16, 3'd2);
      tbl[37] = mkv(1'b1, 8'd19, 5'd21, 32'h0,    1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  3'd3);
      tbl[38] = mkv(1'b0, 8'd0,  5'd0,  32'h0,    1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 8'd0,  3'd0);

      arst = 1'b1;
      drive(1'b0, 8'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk0("reset", 1'b1, 1'b0, 8'd0, 3'd0);
      #11 arst = 1'b0;
      step();

      for (int i = 0; i < 39; i++) begin
         drive(tbl[i].ev, tbl[i].tg, tbl[i].rd, tbl[i].rq, tbl[i].bk, tbl[i].lk,
               tbl[i].ordy, tbl[i].clr);
         #1;
         chk0($sformatf("row%0d", i), tbl[i].irdy, tbl[i].ovld, tbl[i].otag, tbl[i].cnt);
         step();
      end

      // Asynchronous reset between edges drops queued entries at once
      drive(1'b1, 8'd20, 5'd21, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      drive(1'b1, 8'd21, 5'd22, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      #1;
      chk0("pre_arst", 1'b1, 1'b1, 8'd20, 3'd2);
      #1 arst = 1'b1;
      #1;
      chk0("in_arst", 1'b1, 1'b0, 8'd0, 3'd0);
      #1 arst = 1'b0;
      drive(1'b1, 8'd22, 5'd23, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      #1;
      chk0("post_arst", 1'b1, 1'b1, 8'd22, 3'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;

      // In-order instance: independent C must wait behind stalled B
      drive(1'b1, 8'd1, 5'd5, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1; chk1("io0", 1'b1, 1'b0, 8'd0, 3'd0); step();
      drive(1'b1, 8'd2, 5'd0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
      #1; chk1("io1", 1'b1, 1'b1, 8'd1, 3'd1); step();
      drive(1'b1, 8'd3, 5'd7, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1; chk1("io2", 1'b1, 1'b1, 8'd1, 3'd2); step();
      drive(1'b0, 8'd0, 5'd0, 32'h0, 1'b0, 32'h20, 1'b1, 1'b0);
      #1; chk1("io3", 1'b1, 1'b0, 8'd0, 3'd2); step();
      drive(1'b0, 8'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1; chk1("io4", 1'b1, 1'b1, 8'd2, 3'd2); step();
      drive(1'b0, 8'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1; chk1("io5", 1'b1, 1'b1, 8'd3, 3'd1); step();
      drive(1'b0, 8'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1; chk1("io6", 1'b1, 1'b0, 8'd0, 3'd0); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
